gcd_sequencer: RTL and testbench
================================

Name: gcd_sequencer

Overview:
- Control-and-next-value stage for the Euclid GCD datapath. It sits directly upstream of the a/b operand registers and the answer register.
- It drives their load enables and D inputs, reads the register outputs back, and runs subtractive Euclid to completion.
- It provides a start/busy/done handshake to the host, plus error flags and an iteration count.

Parameters:
- W, 16, operand and result width; matches the datapath registers.
- CW, 16, iteration counter width.
- MAX_ITER, 65535, subtraction limit; reaching it aborts the run with err_timeout.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin a GCD; sampled only in IDLE.
- a_in  input  W  operand A, sampled in the start-accept cycle.
- b_in  input  W  operand B, sampled in the start-accept cycle.
- a_q  input  W  current A register output (fed back).
- b_q  input  W  current B register output (fed back).
- a_ld  output  1  A register load enable.
- a_d  output  W  A register next value.
- b_ld  output  1  B register load enable.
- b_d  output  W  B register next value.
- a_eq_b  output  1  answer register capture strobe; the answer register captures a_q.
- busy  output  1  high in CHECK and RUN.
- done  output  1  one-cycle completion pulse.
- err_zero  output  1  both operands were zero; result is 0.
- err_timeout  output  1  the run aborted at MAX_ITER.
- iter_count  output  CW  number of subtractions in the current or last run.

Behaviour:
- Reset: state=IDLE.
  - Combinational outputs a_ld, b_ld, a_eq_b, busy, done are 0.
  - a_d and b_d are 0.
  - Registered outputs err_zero, err_timeout, iter_count are 0.
  - rst mid-run aborts immediately, with no further loads or strobes.
- Outputs a_ld, a_d, b_ld, b_d, a_eq_b are combinational from state, start, a_in/b_in and a_q/b_q. In any case not listed below they are 0.
- State machine with states IDLE, CHECK, RUN, DONE. Cycle 0 is the cycle in which start is accepted.
- IDLE:
  - If start=1: a_ld=b_ld=1, a_d=a_in, b_d=b_in.
  - Same edge: clear err_zero, err_timeout and iter_count; go to CHECK.
  - Otherwise stay in IDLE.
- CHECK (cycle 1): zero-operand handling.
  - If a_q==0 or b_q==0: a_ld=b_ld=1, a_d=b_d=a_q|b_q.
  - If both are zero, set err_zero.
  - Go to RUN in all cases.
- RUN, evaluated in this priority order:
  - a_q==b_q: a_eq_b=1; go to DONE.
  - iter_count==MAX_ITER: set err_timeout; go to DONE with no a_eq_b, so the answer register is not updated.
  - a_q>b_q: a_ld=1, a_d=a_q-b_q; iter_count+1.
  - a_q<b_q: b_ld=1, b_d=b_q-a_q; iter_count+1.
- Arithmetic: unsigned W-bit subtraction. The larger value is always the minuend, so no underflow is possible.
- DONE: done=1 for exactly this cycle, then IDLE.
  - start in DONE is ignored.
  - start is accepted in IDLE on the very next cycle.
- Latency: with k subtractions, done is high in cycle 3+k. RUN spans cycles 2 to 2+k.
- start while busy or in DONE: ignored; the operands are not resampled.
- Error flags and iter_count hold their values until the next accepted start.

Test Plan:
- rst=1, then start=1 with a_in=12, b_in=8 -> cycle0 a_ld=b_ld=1; A=4 after the first RUN cycle; B=4 after the second; a_eq_b in cycle4; answer=4; done in cycle5; iter_count=2; no errors.
- a_in=21, b_in=21 -> a_eq_b in cycle2, done in cycle3, iter_count=0, answer=21.
- a_in=0, b_in=9 -> CHECK loads 9/9 -> answer=9, err_zero=0. Then a_in=0, b_in=0 -> answer=0, err_zero=1.
- MAX_ITER=4, a_in=100, b_in=1 -> after 4 subtractions A=96; err_timeout=1; done pulse; answer register unchanged; iter_count=4.
- Pulse start=1 in cycle 3 of a 12/8 run -> ignored: result is still 4 and a_in/b_in are not resampled. start asserted continuously -> a new run starts in the cycle after done.
- Assert rst in cycle 3 of the a_in=65535, b_in=1 run -> next cycle busy=0, all strobes 0, iter_count=0. A fresh 12/8 run then completes correctly.

Source files
------------

// File: rtl/gcd_sequencer_if.sv
// gcd_sequencer_if
//   Bundles the host handshake, the operand/answer register controls and
//   the status outputs of gcd_sequencer.
//   Ports (through modports):
//     start, a_in, b_in        host request and operands
//     a_q, b_q                 A/B register outputs fed back to the sequencer
//     a_ld, a_d, b_ld, b_d     A/B register load enables and next values
//     a_eq_b                   answer register capture strobe (captures a_q)
//     busy, done               run status and one-cycle completion pulse
//     err_zero, err_timeout    error flags for the last run
//     iter_count               subtractions in the current or last run
//   slave  : used by gcd_sequencer
//   master : used by the host / datapath side
interface gcd_sequencer_if #(
    parameter int W  = 16,
    parameter int CW = 16
);
    logic          start;
    logic [W-1:0]  a_in;
    logic [W-1:0]  b_in;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          a_ld;
    logic [W-1:0]  a_d;
    logic          b_ld;
    logic [W-1:0]  b_d;
    logic          a_eq_b;
    logic          busy;
    logic          done;
    logic          err_zero;
    logic          err_timeout;
    logic [CW-1:0] iter_count;

    modport slave (
        input  start, a_in, b_in, a_q, b_q,
        output a_ld, a_d, b_ld, b_d, a_eq_b, busy, done,
               err_zero, err_timeout, iter_count
    );

    modport master (
        output start, a_in, b_in, a_q, b_q,
        input  a_ld, a_d, b_ld, b_d, a_eq_b, busy, done,
               err_zero, err_timeout, iter_count
    );
endinterface

// File: rtl/gcd_sequencer.sv
// gcd_sequencer
//   Control and next-value stage for a subtractive Euclid GCD datapath.
//   Loads the external A/B registers, reads them back, subtracts the
//   smaller from the larger until they match, then strobes the answer
//   register. Flags both-zero operands and aborts at MAX_ITER subtractions.
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high reset
//     bus   gcd_sequencer_if.slave (handshake, register controls, status)
module gcd_sequencer #(
    parameter int W        = 16,
    parameter int CW       = 16,
    parameter int MAX_ITER = 65535
) (
    input logic            clk,
    input logic            rst,
    gcd_sequencer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, CHECK, RUN, DONE} state_t;

    state_t        state;
    state_t        state_next;

    logic          err_zero_r;
    logic          err_timeout_r;
    logic [CW-1:0] iter_r;

    // Event qualifiers decoded alongside the outputs for the register block.
    logic          accept;
    logic          both_zero;
    logic          timeout_hit;
    logic          step;

    logic          a_ld;
    logic          b_ld;
    logic [W-1:0]  a_d;
    logic [W-1:0]  b_d;
    logic          a_eq_b;
    logic          busy;
    logic          done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            err_zero_r    <= 1'b0;
            err_timeout_r <= 1'b0;
            iter_r        <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                err_zero_r    <= 1'b0;
                err_timeout_r <= 1'b0;
                iter_r        <= '0;
            end
            if (both_zero)   err_zero_r    <= 1'b1;
            if (timeout_hit) err_timeout_r <= 1'b1;
            if (step)        iter_r        <= iter_r + 1'b1;
        end
    end

    // Outputs are gated by rst so a reset mid-run suppresses loads and
    // strobes in the very cycle it is asserted.
    always_comb begin
        state_next  = state;
        a_ld        = 1'b0;
        b_ld        = 1'b0;
        a_d         = '0;
        b_d         = '0;
        a_eq_b      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        accept      = 1'b0;
        both_zero   = 1'b0;
        timeout_hit = 1'b0;
        step        = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        accept     = 1'b1;
                        a_ld       = 1'b1;
                        b_ld       = 1'b1;
                        a_d        = bus.a_in;
                        b_d        = bus.b_in;
                        state_next = CHECK;
                    end
                end
                CHECK: begin
                    busy = 1'b1;
                    // A zero operand makes the GCD the other operand; loading
                    // it into both registers lets RUN finish on equality.
                    if (bus.a_q == '0 || bus.b_q == '0) begin
                        a_ld = 1'b1;
                        b_ld = 1'b1;
                        a_d  = bus.a_q | bus.b_q;
                        b_d  = bus.a_q | bus.b_q;
                    end
                    both_zero  = (bus.a_q == '0) && (bus.b_q == '0);
                    state_next = RUN;
                end
                RUN: begin
                    busy = 1'b1;
                    if (bus.a_q == bus.b_q) begin
                        a_eq_b     = 1'b1;
                        state_next = DONE;
                    end else if (iter_r == CW'(MAX_ITER)) begin
                        timeout_hit = 1'b1;
                        state_next  = DONE;
                    end else if (bus.a_q > bus.b_q) begin
                        a_ld = 1'b1;
                        a_d  = bus.a_q - bus.b_q;
                        step = 1'b1;
                    end else begin
                        b_ld = 1'b1;
                        b_d  = bus.b_q - bus.a_q;
                        step = 1'b1;
                    end
                end
                DONE: begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign bus.a_ld        = a_ld;
    assign bus.a_d         = a_d;
    assign bus.b_ld        = b_ld;
    assign bus.b_d         = b_d;
    assign bus.a_eq_b      = a_eq_b;
    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.err_zero    = err_zero_r;
    assign bus.err_timeout = err_timeout_r;
    assign bus.iter_count  = iter_r;

endmodule

// File: tb/tb_gcd_sequencer.sv
// tb_gcd_sequencer
//   Two sequencers with modelled A/B/answer registers: u_dut uses the
//   default MAX_ITER, u_dut2 uses MAX_ITER=4 for the abort case.
//   Drivers push hand-computed expectations into per-DUT queues; monitors
//   pop and compare whenever done pulses.
module tb_gcd_sequencer;

    logic clk;
    logic rst;

    gcd_sequencer_if #(.W(16), .CW(16)) bus ();
    gcd_sequencer_if #(.W(16), .CW(16)) bus2 ();

    gcd_sequencer #(.W(16), .CW(16), .MAX_ITER(65535)) u_dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    gcd_sequencer #(.W(16), .CW(16), .MAX_ITER(4)) u_dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    logic [15:0] ra, rb, rans;
    logic [15:0] ra2, rb2, rans2;

    assign bus.a_q  = ra;
    assign bus.b_q  = rb;
    assign bus2.a_q = ra2;
    assign bus2.b_q = rb2;

    always @(posedge clk) begin
        if (bus.a_ld)    ra    <= bus.a_d;
        if (bus.b_ld)    rb    <= bus.b_d;
        if (bus.a_eq_b)  rans  <= bus.a_q;
        if (bus2.a_ld)   ra2   <= bus2.a_d;
        if (bus2.b_ld)   rb2   <= bus2.b_d;
        if (bus2.a_eq_b) rans2 <= bus2.a_q;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        int ans;
        int iter;
        bit ez;
        bit et;
        int accept;
        bit chk_a;
        int a;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.done) begin
            if (q1.size() == 0) check("dut1_unexpected_done", 1, 0);
            else begin
                e = q1.pop_front();
                check("dut1_answer",      rans,               e.ans);
                check("dut1_iter_count",  bus.iter_count,     e.iter);
                check("dut1_err_zero",    bus.err_zero,       e.ez);
                check("dut1_err_timeout", bus.err_timeout,    e.et);
                check("dut1_latency",     cyc - e.accept,     3 + e.iter);
                if (e.chk_a) check("dut1_a_reg", ra, e.a);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus2.done) begin
            if (q2.size() == 0) check("dut2_unexpected_done", 1, 0);
            else begin
                e = q2.pop_front();
                check("dut2_answer",      rans2,              e.ans);
                check("dut2_iter_count",  bus2.iter_count,    e.iter);
                check("dut2_err_zero",    bus2.err_zero,      e.ez);
                check("dut2_err_timeout", bus2.err_timeout,   e.et);
                check("dut2_latency",     cyc - e.accept,     3 + e.iter);
                if (e.chk_a) check("dut2_a_reg", ra2, e.a);
            end
        end
    end

    task automatic wait_idle(input bit sel);
        int n = 0;
        @(negedge clk);
        while ((sel ? (bus2.busy || bus2.done) : (bus.busy || bus.done)) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("wait_idle_bound", 0, 1);
    endtask

    // Issue one start (one cycle) and push its expectation. Returns at the
    // negedge of cycle 1 of the run, with accept holding the cycle-0 index.
    task automatic issue(input bit sel, input int a, input int b, input int ans,
                         input int iter, input bit ez, input bit et,
                         input bit chk_a, input int exp_a, input bit push,
                         output int accept);
        exp_t e;
        wait_idle(sel);
        if (sel) begin bus2.start = 1'b1; bus2.a_in = 16'(a); bus2.b_in = 16'(b); end
        else     begin bus.start  = 1'b1; bus.a_in  = 16'(a); bus.b_in  = 16'(b); end
        #1;
        if (sel) begin
            check("cycle0_a_ld", bus2.a_ld, 1);
            check("cycle0_b_ld", bus2.b_ld, 1);
            check("cycle0_a_d",  bus2.a_d,  a);
        end else begin
            check("cycle0_a_ld", bus.a_ld, 1);
            check("cycle0_b_ld", bus.b_ld, 1);
            check("cycle0_b_d",  bus.b_d,  b);
        end
        accept   = cyc;
        e.ans    = ans; e.iter = iter; e.ez = ez; e.et = et;
        e.accept = accept; e.chk_a = chk_a; e.a = exp_a;
        if (push) begin
            if (sel) q2.push_back(e);
            else     q1.push_back(e);
        end
        @(negedge clk);
        if (sel) bus2.start = 1'b0;
        else     bus.start  = 1'b0;
    endtask

    task automatic wait_done1();
        int n = 0;
        while (!bus.done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("wait_done_bound", 0, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int acc;
        exp_t e;
        rst = 1'b1;
        bus.start = 1'b0;  bus.a_in = '0;  bus.b_in = '0;
        bus2.start = 1'b0; bus2.a_in = '0; bus2.b_in = '0;

        // Reset: start held high must still produce no loads.
        repeat (2) @(negedge clk);
        bus.start = 1'b1; bus.a_in = 16'd5; bus.b_in = 16'd3;
        #1;
        check("rst_a_ld",        bus.a_ld,        0);
        check("rst_b_ld",        bus.b_ld,        0);
        check("rst_a_d",         bus.a_d,         0);
        check("rst_b_d",         bus.b_d,         0);
        check("rst_a_eq_b",      bus.a_eq_b,      0);
        check("rst_busy",        bus.busy,        0);
        check("rst_done",        bus.done,        0);
        check("rst_err_zero",    bus.err_zero,    0);
        check("rst_err_timeout", bus.err_timeout, 0);
        check("rst_iter_count",  bus.iter_count,  0);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // 12/8: A=4 after first RUN, B=4 after second, answer 4, 2 steps.
        issue(0, 12, 8, 4, 2, 0, 0, 0, 0, 1, acc);
        check("busy_check", bus.busy, 1);
        @(negedge clk);            // cycle 2 (RUN)
        check("busy_run", bus.busy, 1);
        @(negedge clk);            // cycle 3
        check("a_after_run1", ra, 4);
        @(negedge clk);            // cycle 4
        check("b_after_run2", rb, 4);
        check("a_eq_b_cycle4", bus.a_eq_b, 1);

        // Equal operands: no subtractions.
        issue(0, 21, 21, 21, 0, 0, 0, 0, 0, 1, acc);
        // Single zero operand: result is the other one.
        issue(0, 0, 9, 9, 0, 0, 0, 0, 0, 1, acc);
        // Both zero: result 0, err_zero set and held afterwards.
        issue(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, acc);
        wait_idle(0);
        repeat (2) @(negedge clk);
        check("err_zero_hold", bus.err_zero, 1);
        // Longer run: gcd(35,14)=7: 35-14=21, 21-14=7, 14-7=7 -> 3 steps.
        issue(0, 35, 14, 7, 3, 0, 0, 0, 0, 1, acc);

        // Start pulsed in cycle 3 of a 12/8 run is ignored.
        issue(0, 12, 8, 4, 2, 0, 0, 0, 0, 1, acc);
        @(negedge clk);            // cycle 2
        @(negedge clk);            // cycle 3
        bus.start = 1'b1; bus.a_in = 16'd50; bus.b_in = 16'd7;
        @(negedge clk);
        bus.start = 1'b0;

        // Start held high: a new run begins the cycle after done.
        wait_idle(0);
        bus.start = 1'b1; bus.a_in = 16'd12; bus.b_in = 16'd8;
        e.ans = 4; e.iter = 2; e.ez = 0; e.et = 0; e.accept = cyc; e.chk_a = 0; e.a = 0;
        q1.push_back(e);
        @(negedge clk);
        wait_done1();
        bus.a_in = 16'd21; bus.b_in = 16'd21;
        e.ans = 21; e.iter = 0; e.accept = cyc + 1;
        q1.push_back(e);
        @(negedge clk);
        #1;
        check("back_to_back_a_ld", bus.a_ld, 1);
        check("back_to_back_a_d",  bus.a_d,  21);
        @(negedge clk);
        bus.start = 1'b0;

        // Reset in cycle 3 of a 65535/1 run: aborts with no further loads.
        issue(0, 65535, 1, 0, 0, 0, 0, 0, 0, 0, acc);
        @(negedge clk);            // cycle 2
        @(negedge clk);            // cycle 3
        rst = 1'b1;
        #1;
        check("rst_mid_a_ld", bus.a_ld, 0);
        check("rst_mid_busy", bus.busy, 0);
        @(negedge clk);            // cycle 4
        check("post_rst_busy",       bus.busy,       0);
        check("post_rst_a_ld",       bus.a_ld,       0);
        check("post_rst_b_ld",       bus.b_ld,       0);
        check("post_rst_a_eq_b",     bus.a_eq_b,     0);
        check("post_rst_done",       bus.done,       0);
        check("post_rst_iter_count", bus.iter_count, 0);
        check("post_rst_a_reg",      ra,             65534);
        rst = 1'b0;
        issue(0, 12, 8, 4, 2, 0, 0, 0, 0, 1, acc);

        // MAX_ITER=4: first set the answer register to 4, then time out.
        issue(1, 12, 8, 4, 2, 0, 0, 0, 0, 1, acc);
        issue(1, 100, 1, 4, 4, 0, 1, 1, 96, 1, acc);
        wait_idle(1);

        begin
            int n = 0;
            while ((q1.size() != 0 || q2.size() != 0) && n < 500) begin
                @(negedge clk);
                n++;
            end
            check("scoreboard_drained", q1.size() + q2.size(), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
